nn_feed_seq: RTL and testbench
==============================

Name: nn_feed_seq

Overview:
- Upstream stage of the NN controller. Buffers one texture-feature vector from the feature extractor.
- For each hidden neuron in turn, streams the pairs (feature, weight), then a bias beat, as the controller's `in`/`weib` operand stream.
- Weights come from an external synchronous-read weight ROM. One complete vector is processed per sweep; the next vector is accepted only after the sweep ends.

Parameters:
- N_FEAT, 16: features per vector.
- N_NEUR, 8: neurons swept per vector.
- DW, 16: data width of features, weights and bias.
- AW, $clog2(N_NEUR*(N_FEAT+1)): weight ROM address width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- feat_valid  in  1  feature beat valid
- feat_ready  out  1  block can accept a feature beat
- feat_data  in  DW  feature value
- feat_last  in  1  last beat of the vector
- w_addr  out  AW  weight ROM address
- w_en  out  1  ROM read strobe; w_data is valid the cycle after
- w_data  in  DW  ROM read data
- out_valid  out  1  operand pair valid
- out_ready  in  1  downstream accepts the pair
- in_o  out  DW  feature operand (0 on bias beat)
- weib_o  out  DW  weight or bias operand
- is_bias_o  out  1  current beat is the bias of neuron_o
- neuron_o  out  8  index of the neuron being fed
- vec_done  out  1  one-cycle pulse after the last bias beat is accepted
- ovf_err  out  1  sticky: the vector exceeded N_FEAT beats

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk.
- Reset values: state=LOAD, all counters=0, out_valid=0, w_en=0, w_addr=0, in_o=0, weib_o=0, is_bias_o=0, neuron_o=0, vec_done=0, ovf_err=0, feature buffer cleared to 0.
- feat_ready = (state==LOAD). It reads 1 while in reset.
- Reset mid-sweep aborts the sweep and discards the buffered vector.

States: LOAD, RUN, FLUSH.
- LOAD:
  - Each cycle with feat_valid&&feat_ready, write feat_data to buf[fcnt] and increment fcnt.
  - If fcnt==N_FEAT, drop the beat and set ovf_err.
  - On an accepted beat with feat_last=1, go to RUN with neuron=0, k=0.
  - Unfilled entries stay 0, so a short vector is zero-padded.
- RUN, issue rule:
  - Assert w_en with w_addr = neuron*(N_FEAT+1)+k only when no read is in flight and (!out_valid || out_ready).
  - Effective throughput is therefore 1 pair per 2 clk.
- RUN, landing beat (the cycle after w_en):
  - out_valid<=1, weib_o<=w_data.
  - in_o<=buf[k_d], or 0 if k_d==N_FEAT.
  - is_bias_o<=(k_d==N_FEAT), neuron_o<=neuron_d.
  - k_d and neuron_d are the k and neuron values delayed by one cycle.
- Counter advance on issue:
  - k increments per issue.
  - At k==N_FEAT, k goes to 0 and neuron increments.
  - After issuing the bias of neuron N_NEUR-1, go to FLUSH.
- out_valid handshake:
  - Clears on out_ready unless a new beat lands in the same cycle.
  - While out_valid && !out_ready, all output fields are held stable.
- FLUSH:
  - Wait for the final beat to be accepted.
  - Then pulse vec_done, reset fcnt, clear the buffer, return to LOAD.
  - ovf_err clears only on reset.
- Address arithmetic is unsigned. The maximum address is N_NEUR*(N_FEAT+1)-1 and must fit in AW.
- In FLUSH, out_ready and a new feat_valid may arrive in the same cycle. The feature beat is not accepted in that cycle because feat_ready=0; acceptance starts the following cycle.

Decomposition:
- Shared package nn_pkg: DW, state encoding (LOAD/RUN/FLUSH), the bias-slot offset convention (bias at word N_FEAT of each neuron's block). The NN controller reuses the same package.
- One natural sub-module: nn_feat_buf, an N_FEAT x DW register file with write port, combinational read and synchronous clear.

Test Plan (N_FEAT=4, N_NEUR=2, ROM[a]=a+100):
1. Load features 1,2,3,4 (last on 4), out_ready=1 → 10 beats:
   - neuron 0: (1,100) (2,101) (3,102) (4,103) (0,104,bias)
   - neuron 1: (1,105) … (0,109,bias)
   - vec_done pulses once; w_en spacing is 2 clk.
2. Short vector 7,8 (last on 8) → neuron 0 beats (7,100) (8,101) (0,102) (0,103), then bias (0,104).
3. Six beats, last on 6th → beats 5 and 6 dropped, ovf_err=1 and stays 1 across the next vector; data identical to scenario 1.
4. out_ready held 0 for 5 clk on beat (2,101) → outputs stable, no w_en during the stall, sequence resumes with (3,102).
5. Reset asserted at the 3rd output beat → out_valid=0, feat_ready=1 immediately. A fresh vector 9,9,9,9 starts again at w_addr=0 with (9,100).
6. feat_valid=1 during RUN → feat_ready=0 and nothing is written. The next vector is accepted the cycle after vec_done.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the NN controller datapath: data width, sequencer states
// and the per-neuron weight ROM layout.
package nn_pkg;

    localparam int DW = 16;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } nn_state_e;

    // Each neuron owns N_FEAT+1 consecutive ROM words; its bias sits at word N_FEAT.
    function automatic int unsigned bias_slot(input int unsigned n_feat);
        return n_feat;
    endfunction

endpackage

// File: rtl/nn_feat_buf.sv
// Feature vector register file: one write port, combinational read, synchronous clear.
// Reading the bias slot (index N_FEAT) returns zero.
module nn_feat_buf
    import nn_pkg::*;
#(
    parameter int N_FEAT = 16,
    parameter int DW     = nn_pkg::DW,
    parameter int IW     = $clog2(N_FEAT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int AIW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    logic [DW-1:0] mem_r [N_FEAT];

    // Storage: async reset and sync clear both zero every entry so short vectors read as padded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_FEAT; i++) mem_r[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_FEAT; i++) mem_r[i] <= '0;
        end else if (we && (int'(waddr) < N_FEAT)) begin
            mem_r[waddr[AIW-1:0]] <= wdata;
        end
    end

    // Read port: out-of-range index is the bias slot and yields zero.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < N_FEAT) begin
            rdata = mem_r[raddr[AIW-1:0]];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/nn_feed_seq.sv
// Feature/weight operand sequencer: buffers one feature vector, then streams
// (feature, weight) pairs and a bias beat per neuron from a synchronous weight ROM.
module nn_feed_seq
    import nn_pkg::*;
#(
    parameter int N_FEAT = 16,
    parameter int N_NEUR = 8,
    parameter int DW     = nn_pkg::DW,
    parameter int AW     = $clog2(N_NEUR * (N_FEAT + 1))
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          feat_valid,
    output logic          feat_ready,
    input  logic [DW-1:0] feat_data,
    input  logic          feat_last,
    output logic [AW-1:0] w_addr,
    output logic          w_en,
    input  logic [DW-1:0] w_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] in_o,
    output logic [DW-1:0] weib_o,
    output logic          is_bias_o,
    output logic [7:0]    neuron_o,
    output logic          vec_done,
    output logic          ovf_err
);

    localparam int          KW        = $clog2(N_FEAT + 1);
    localparam int unsigned BIAS_K    = bias_slot(N_FEAT);
    localparam logic [KW-1:0] K_BIAS  = KW'(BIAS_K);
    localparam logic [KW-1:0] K_FULL  = KW'(N_FEAT);
    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [AW-1:0] A_ONE   = AW'(1);
    localparam logic [7:0]  LAST_NEUR = 8'(N_NEUR - 1);

    nn_state_e     state_r;
    logic [KW-1:0] fcnt_r, k_r, kd_r;
    logic [7:0]    neuron_r, neurond_r, neuron_o_r;
    logic [AW-1:0] addr_r;
    logic          rd_pend_r, out_valid_r, is_bias_r, vec_done_r, ovf_err_r;
    logic [DW-1:0] in_r, weib_r, buf_rdata_s;
    logic          issue_s, buf_we_s, done_s;

    // Handshake decode. The ROM strobe depends on out_ready so a read is only
    // launched when its landing slot is guaranteed free, giving one pair per 2 clk.
    always_comb begin
        issue_s  = 1'b0;
        buf_we_s = 1'b0;
        done_s   = 1'b0;
        if (state_r == ST_RUN && !rd_pend_r && (!out_valid_r || out_ready)) issue_s = 1'b1;
        else issue_s = 1'b0;
        if (state_r == ST_LOAD && feat_valid && fcnt_r != K_FULL) buf_we_s = 1'b1;
        else buf_we_s = 1'b0;
        if (state_r == ST_FLUSH && !rd_pend_r && out_valid_r && out_ready) done_s = 1'b1;
        else done_s = 1'b0;
    end

    nn_feat_buf #(.N_FEAT(N_FEAT), .DW(DW), .IW(KW)) u_buf (
        .clk   (clk),
        .reset (reset),
        .clr   (done_s),
        .we    (buf_we_s),
        .waddr (fcnt_r),
        .wdata (feat_data),
        .raddr (kd_r),
        .rdata (buf_rdata_s)
    );

    // Sequencer FSM with counters and registered operand outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_LOAD;
            fcnt_r      <= '0;
            k_r         <= '0;
            kd_r        <= '0;
            neuron_r    <= 8'd0;
            neurond_r   <= 8'd0;
            neuron_o_r  <= 8'd0;
            addr_r      <= '0;
            rd_pend_r   <= 1'b0;
            out_valid_r <= 1'b0;
            is_bias_r   <= 1'b0;
            vec_done_r  <= 1'b0;
            ovf_err_r   <= 1'b0;
            in_r        <= '0;
            weib_r      <= '0;
        end else begin
            vec_done_r <= 1'b0;
            rd_pend_r  <= issue_s;
            if (rd_pend_r) begin
                out_valid_r <= 1'b1;
                weib_r      <= w_data;
                in_r        <= buf_rdata_s;
                is_bias_r   <= (kd_r == K_BIAS);
                neuron_o_r  <= neurond_r;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (issue_s) begin
                kd_r      <= k_r;
                neurond_r <= neuron_r;
            end
            case (state_r)
                ST_LOAD: begin
                    if (feat_valid) begin
                        if (fcnt_r == K_FULL) ovf_err_r <= 1'b1;
                        else fcnt_r <= fcnt_r + K_ONE;
                        if (feat_last) begin
                            state_r  <= ST_RUN;
                            k_r      <= '0;
                            neuron_r <= 8'd0;
                            addr_r   <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        if (k_r == K_BIAS) begin
                            k_r <= '0;
                            if (neuron_r == LAST_NEUR) begin
                                neuron_r <= 8'd0;
                                addr_r   <= '0;
                                state_r  <= ST_FLUSH;
                            end else begin
                                neuron_r <= neuron_r + 8'd1;
                                addr_r   <= addr_r + A_ONE;
                            end
                        end else begin
                            k_r    <= k_r + K_ONE;
                            addr_r <= addr_r + A_ONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (done_s) begin
                        vec_done_r <= 1'b1;
                        fcnt_r     <= '0;
                        state_r    <= ST_LOAD;
                    end
                end
                default: state_r <= ST_LOAD;
            endcase
        end
    end

    assign feat_ready = (state_r == ST_LOAD);
    assign w_en       = issue_s;
    assign w_addr     = addr_r;
    assign out_valid  = out_valid_r;
    assign in_o       = in_r;
    assign weib_o     = weib_r;
    assign is_bias_o  = is_bias_r;
    assign neuron_o   = neuron_o_r;
    assign vec_done   = vec_done_r;
    assign ovf_err    = ovf_err_r;

endmodule

// File: tb/tb_nn_feed_seq.sv
// Directed bench for nn_feed_seq with N_FEAT=4, N_NEUR=2 and a weight ROM holding addr+100.
module tb_nn_feed_seq;

    localparam int NF = 4;
    localparam int NN = 2;
    localparam int AW = $clog2(NN * (NF + 1));

    logic          clk, reset;
    logic          feat_valid, feat_ready, feat_last;
    logic [15:0]   feat_data;
    logic [AW-1:0] w_addr;
    logic          w_en;
    logic [15:0]   w_data;
    logic          out_valid, out_ready;
    logic [15:0]   in_o, weib_o;
    logic          is_bias_o;
    logic [7:0]    neuron_o;
    logic          vec_done, ovf_err;

    int passed = 0;
    int total  = 0;
    int wen_cnt = 0;
    logic [15:0] vec [8];

    nn_feed_seq #(.N_FEAT(NF), .N_NEUR(NN), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data), .feat_last(feat_last),
        .w_addr(w_addr), .w_en(w_en), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .in_o(in_o), .weib_o(weib_o), .is_bias_o(is_bias_o), .neuron_o(neuron_o),
        .vec_done(vec_done), .ovf_err(ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read weight ROM model and strobe counter.
    always @(posedge clk) begin
        if (w_en) begin
            w_data  <= 16'(w_addr) + 16'd100;
            wen_cnt <= wen_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input int n);
        for (int i = 0; i < n; i++) begin
            feat_valid = 1'b1;
            feat_data  = vec[i];
            feat_last  = (i == n - 1);
            tick();
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    // Collect the 10 beats of one sweep and compare against the bench's own model.
    task automatic run_vec(input int len, input int stall_at, input int abort_at);
        int waitc, nn, k, c0;
        logic [15:0] exp_in;
        for (int b = 0; b < NN * (NF + 1); b++) begin
            waitc = 0;
            while (out_valid !== 1'b1 && waitc < 40) begin
                tick();
                waitc++;
            end
            chk($sformatf("beat_wait_b%0d", b), 32'(waitc < 40), 32'd1);
            if (waitc >= 40) return;
            nn = b / (NF + 1);
            k  = b % (NF + 1);
            exp_in = (k < NF && k < len) ? vec[k] : 16'd0;
            chk($sformatf("in_b%0d", b), 32'(in_o), 32'(exp_in));
            chk($sformatf("weib_b%0d", b), 32'(weib_o), 32'(b + 100));
            chk($sformatf("bias_b%0d", b), 32'(is_bias_o), 32'(k == NF));
            chk($sformatf("neuron_b%0d", b), 32'(neuron_o), 32'(nn));
            if (b < NN * (NF + 1) - 1) begin
                chk($sformatf("wen_b%0d", b), 32'(w_en), 32'd1);
                chk($sformatf("waddr_b%0d", b), 32'(w_addr), 32'(b + 1));
            end else begin
                chk("wen_after_last", 32'(w_en), 32'd0);
            end
            if (b == stall_at) begin
                out_ready = 1'b0;
                c0 = wen_cnt;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk($sformatf("stall_valid_%0d", s), 32'(out_valid), 32'd1);
                    chk($sformatf("stall_in_%0d", s), 32'(in_o), 32'(exp_in));
                    chk($sformatf("stall_weib_%0d", s), 32'(weib_o), 32'(b + 100));
                end
                chk("stall_no_wen", 32'(wen_cnt - c0), 32'd0);
                out_ready = 1'b1;
            end
            if (b == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_ready", 32'(feat_ready), 32'd1);
                chk("abort_waddr", 32'(w_addr), 32'd0);
                chk("abort_ovf", 32'(ovf_err), 32'd0);
                tick();
                reset = 1'b0;
                return;
            end
            tick();
        end
        chk("vec_done_pulse", 32'(vec_done), 32'd1);
        chk("ready_after_done", 32'(feat_ready), 32'd1);
        chk("valid_after_done", 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        feat_valid = 1'b0;
        feat_data  = 16'd0;
        feat_last  = 1'b0;
        out_ready  = 1'b1;
        #1;
        chk("rst_feat_ready", 32'(feat_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_outputs", {in_o, weib_o}, 32'd0);
        chk("rst_flags", {23'd0, is_bias_o, neuron_o}, 32'd0);
        chk("rst_done_ovf", {30'd0, vec_done, ovf_err}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Full vector, continuous acceptance.
        vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
        load_vec(4);
        chk("run_blocks_feat", 32'(feat_ready), 32'd0);
        run_vec(4, -1, -1);
        chk("ovf_clear", 32'(ovf_err), 32'd0);
        tick();
        chk("vec_done_one_cycle", 32'(vec_done), 32'd0);

        // Short vector is zero-padded.
        vec = '{16'd7, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        load_vec(2);
        run_vec(2, -1, -1);
        tick();

        // Overlong vector: extra beats dropped, sticky overflow.
        vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0};
        load_vec(6);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        run_vec(6, -1, -1);
        tick();

        // Downstream stall on beat (2,101).
        vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
        load_vec(4);
        run_vec(4, 1, -1);
        chk("ovf_sticky", 32'(ovf_err), 32'd1);
        tick();

        // Reset mid-sweep, then a fresh vector from address 0.
        load_vec(4);
        run_vec(4, -1, 2);
        vec = '{16'd9, 16'd9, 16'd9, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0};
        load_vec(4);
        run_vec(4, -1, -1);
        tick();

        // Feature beats offered during the sweep must not be written.
        vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
        load_vec(4);
        feat_valid = 1'b1;
        feat_data  = 16'h0055;
        feat_last  = 1'b0;
        #1;
        chk("run_ready_low", 32'(feat_ready), 32'd0);
        run_vec(4, -1, -1);
        vec = '{16'h0055, 16'h0066, 16'h0077, 16'h0088, 16'd0, 16'd0, 16'd0, 16'd0};
        load_vec(4);
        run_vec(4, -1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
